// File: rtl/sparc_icc_branch_unit.sv
// SPARC icc register and Bicc resolver: latches ALU flags, evaluates branch
// conditions, issues a registered redirect and tracks the annullable delay slot.
// Optional macro ICC_BYPASS_EN forwards same-cycle flags_in into condition evaluation.
module sparc_icc_branch_unit #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       flags_in,
    input  logic             cc_we,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    input  logic             br_annul,
    input  logic [PC_W-1:0]  br_target,
    input  logic             inst_valid,
    output logic             br_ready,
    output logic [3:0]       icc,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             slot_kill,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_t;

    state_t     state;
    logic       annul_q;
    logic [3:0] cc_src;
    logic       cc_n, cc_z, cc_v, cc_c;
    logic       base_c;
    logic       eval_c;

    // Condition-code source feeding the evaluator
`ifdef ICC_BYPASS_EN
    assign cc_src = (cc_we && !stall) ? flags_in : icc;
`else
    assign cc_src = icc;
`endif

    assign cc_n = cc_src[3];
    assign cc_z = cc_src[2];
    assign cc_v = cc_src[1];
    assign cc_c = cc_src[0];

    // Conditions 1001-1111 are complements of 0001-0111; 1000 is the complement of never
    always_comb begin
        base_c = 1'b0;
        case (br_cond[2:0])
            3'd0:    base_c = 1'b0;
            3'd1:    base_c = cc_z;
            3'd2:    base_c = cc_z | (cc_n ^ cc_v);
            3'd3:    base_c = cc_n ^ cc_v;
            3'd4:    base_c = cc_c | cc_z;
            3'd5:    base_c = cc_c;
            3'd6:    base_c = cc_n;
            3'd7:    base_c = cc_v;
            default: base_c = 1'b0;
        endcase
        eval_c = base_c ^ br_cond[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            icc         <= 4'b0000;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            taken_cnt   <= '0;
            annul_q     <= 1'b0;
        end else begin
            // Redirect is a single-cycle pulse even while stalled
            redirect <= 1'b0;
            if (!stall) begin
                if (cc_we) begin
                    icc <= flags_in;
                end
                case (state)
                    IDLE: begin
                        if (br_valid) begin
                            state    <= SLOT;
                            annul_q  <= br_annul && (!eval_c || (br_cond == 4'b1000));
                            redirect <= eval_c;
                            if (eval_c) begin
                                redirect_pc <= br_target;
                                taken_cnt   <= taken_cnt + CNT_W'(1);
                            end
                        end
                    end
                    SLOT: begin
                        if (inst_valid) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign br_ready  = (state == IDLE);
    assign slot_kill = (state == SLOT) && annul_q;

endmodule

// File: doc/sparc_icc_branch_unit.md
# sparc_icc_branch_unit

Integer condition-code register and branch resolver that sits directly downstream of `mini_alu`. It latches the ALU's 4-bit `flags` into the SPARC `icc` register and evaluates Bicc condition fields against it. It issues a registered redirect to the fetch stage and tracks the single delay-slot instruction, marking it for annulment per SPARC rules.

## Interface
- `PC_W`, default 32: width of branch target and redirect PC.
- `CNT_W`, default 16: width of taken-branch counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `flags_in`  in  4  from `mini_alu.flags`: [3]=N, [2]=Z, [1]=V, [0]=C
- `cc_we`  in  1  current ALU op is a cc-setting variant; write `icc`
- `stall`  in  1  pipeline freeze; blocks all state updates
- `br_valid`  in  1  Bicc instruction presented
- `br_cond`  in  4  SPARC cond field
- `br_annul`  in  1  instruction `a` bit
- `br_target`  in  PC_W  computed branch target
- `inst_valid`  in  1  an instruction issues this cycle (used to retire the delay slot)
- `br_ready`  out  1  unit can accept a branch
- `icc`  out  4  condition-code register {N,Z,V,C}
- `redirect`  out  1  one-cycle pulse: fetch must jump
- `redirect_pc`  out  PC_W  target, valid with `redirect`
- `slot_kill`  out  1  delay-slot instruction must be annulled
- `taken_cnt`  out  CNT_W  count of taken branches, wraps

## Operation
- `icc` update: on a clock edge, if `cc_we && !stall`, then `icc <= flags_in`; otherwise hold.
- Condition evaluation, with `c` as the selected cc value:
  - 0000 never
  - 0001 Z
  - 0010 Z|(N^V)
  - 0011 N^V
  - 0100 C|Z
  - 0101 C
  - 0110 N
  - 0111 V
  - 1000 always
  - 1001–1111: complements of 0001–0111 in the same order
- FSM states:
  - IDLE: `br_ready`=1.
  - SLOT: `br_ready`=0.
- IDLE→SLOT on `br_valid && !stall`. In that cycle:
  - `taken_q <= eval`
  - `annul_q <= br_annul && (!eval || br_cond==4'b1000)`
  - `redirect <= eval`
  - `redirect_pc <= br_target` when taken, otherwise hold
  - `taken_cnt` increments if taken
- SLOT→IDLE on `inst_valid && !stall`. This is the delay-slot instruction.
- `slot_kill` = (state==SLOT) && `annul_q`, combinational.
- `br_valid` while in SLOT is ignored (branch in a delay slot is not supported). Upstream holds it until `br_ready`.
- `redirect` is a pulse: cleared on the next edge unless re-set.
- Arithmetic: `taken_cnt` is modulo 2^CNT_W, and all-ones+1 = 0.

## Timing
- Reset (asynchronous, any time, including mid-SLOT):
  - state=IDLE, `icc`=0000, `redirect`=0, `redirect_pc`=0
  - `taken_cnt`=0, `taken_q`=0, `annul_q`=0
  - `br_ready`=1, `slot_kill`=0
- Branch acceptance to `redirect` high: 1 cycle. `redirect_pc` is stable in that same cycle.
- `icc` is visible one cycle after the `cc_we` edge.
- `stall`=1: no register changes. `redirect` still clears after its single cycle, because a pulse must not repeat.
- A `br_valid` and `cc_we` in the same cycle use the cc source defined under Configuration.
- SLOT lasts until the first un-stalled `inst_valid`, with no upper bound.

## Configuration
- Macro: `ICC_BYPASS_EN`.
- Defined: when `cc_we && !stall`, condition evaluation uses `flags_in` (forwarded); otherwise it uses `icc`.
- Undefined: evaluation always uses registered `icc`. The compiler/decoder guarantees one instruction between a cc-setting op and a dependent Bicc.

## Test plan
- Reset, then drive a Z-setting flag without a branch: check all outputs are 0, `br_ready`=1. Then `flags_in`=4'b0100 with `cc_we`=1: `icc`=0100 next cycle.
- `icc`=0100, BE (0001), a=0, target 0x0000_0040: `redirect` pulses one cycle with `redirect_pc`=0x40, `slot_kill`=0, `taken_cnt`=1. Next `inst_valid` returns to IDLE.
- `icc`=0000, BNE is taken, while BE,a (0001, a=1) is not taken: `redirect`=0 and `slot_kill`=1 throughout SLOT until `inst_valid`.
- BA,a (1000, a=1): `redirect`=1 and `slot_kill`=1. BN (0000, a=0): no redirect, `slot_kill`=0.
- Same-cycle `cc_we` with `flags_in`=0100 and BE while `icc`=0000: taken with `ICC_BYPASS_EN`, not taken without.
- Protocol corner cases:
  - `br_valid` during SLOT is ignored.
  - `stall`=1 during SLOT with `inst_valid` keeps the unit in SLOT.
  - `rst_n` pulsed low mid-SLOT gives IDLE and `slot_kill`=0 immediately.
  - With `taken_cnt` preloaded to 0xFFFF via 65535 taken branches, the next taken branch gives 0.
